// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding on LRCLK, receiver FSM states, default width.
package i2s_pkg;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  localparam int I2S_DEFAULT_WIDTH = 16;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchroniser for one asynchronous I2S line, with a rising-edge flag
// derived from the synchronised level.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_p;
  logic              q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
      q_prev <= sync_p[STAGES-1];
    end
  end

  assign q    = sync_p[STAGES-1];
  assign rise = q & ~q_prev;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: oversamples BCLK/LRCLK/DIN in the clk domain and delivers
// left/right sample pairs with a single strobe.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int WIDTH       = I2S_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] audio_l,
  output logic [WIDTH-1:0] audio_r,
  output logic             sample_strobe,
  output logic             frame_err
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

  logic             bclk_s_unused, lr_rise_unused, din_rise_unused;
  logic             bclk_rise, lr_s, din_s;
  rx_state_t        state, state_nxt;
  logic             lr_prev, left_valid, boundary;
  logic [WIDTH-1:0] shreg, word_nxt, left_hold;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             word_done, done_left, done_right, done_short;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(clk), .reset(reset), .d(i2s_bclk), .q(bclk_s_unused), .rise(bclk_rise)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk(clk), .reset(reset), .d(i2s_lrclk), .q(lr_s), .rise(lr_rise_unused)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
    .clk(clk), .reset(reset), .d(i2s_din), .q(din_s), .rise(din_rise_unused)
  );

  assign boundary = bclk_rise && (lr_s != lr_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == WAIT_SYNC && boundary) state_nxt = RUN;
  end

  // The bit sampled on a boundary rise still belongs to the old word, so the
  // completed word is always shreg with the current bit already placed.
  always_comb begin
    word_nxt = shreg;
    cnt_nxt  = cnt;
    if (cnt < CNT_FULL) begin
      word_nxt = din_s ? (shreg | (MSB_ONE >> cnt)) : shreg;
      cnt_nxt  = cnt + CW'(1);
    end
    word_done  = (state == RUN) && boundary;
    done_left  = word_done && (lr_prev == I2S_LEFT);
    done_right = word_done && (lr_prev == I2S_RIGHT);
    done_short = word_done && (cnt_nxt < CNT_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lr_prev       <= I2S_LEFT;
      shreg         <= '0;
      cnt           <= '0;
      left_valid    <= 1'b0;
      audio_l       <= '0;
      audio_r       <= '0;
      sample_strobe <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      frame_err     <= done_short;
      if (bclk_rise) begin
        lr_prev <= lr_s;
        if (word_done) begin
          shreg <= '0;
          cnt   <= '0;
        end else if (state == RUN) begin
          shreg <= word_nxt;
          cnt   <= cnt_nxt;
        end
      end
      if (done_left) left_valid <= 1'b1;
      // A right word with no pending left is dropped without a strobe.
      if (done_right && left_valid) begin
        audio_l       <= left_hold;
        audio_r       <= word_nxt;
        sample_strobe <= 1'b1;
        left_valid    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done_left) left_hold <= word_nxt;
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives I2S frames bit by bit and checks every
// strobe / frame_err against a queue of expected events built from the sent words.
module tb_i2s_receiver;
  import i2s_pkg::*;

  localparam int W  = 16;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset, i2s_bclk, i2s_lrclk, i2s_din;
  logic [W-1:0] audio_l, audio_r;
  logic         sample_strobe, frame_err;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        stb;
    logic        err;
    int          cyc;
  } ev_t;

  ev_t         evq[$];
  ev_t         mon_e;
  int          checks = 0, passed = 0, cyc = 0;
  int          n_stb_exp = 0, n_stb_seen = 0;
  bit          m_run, m_lv, has_pend;
  logic [15:0] m_lhold, m_out_l, m_out_r;
  logic        cur_ch, pend_bit;
  logic [31:0] cur_data;
  int          cur_n;

  i2s_receiver #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_din(i2s_din), .audio_l(audio_l), .audio_r(audio_r),
    .sample_strobe(sample_strobe), .frame_err(frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] align(input logic [31:0] d, input int n);
    logic [31:0] t;
    if (n >= 16) t = d >> (n - 16);
    else         t = d << (16 - n);
    return t[15:0];
  endfunction

  // act: 0 none, 1 pulse reset in low phase, 2 release reset, 3 sub-bit LRCLK glitch
  task automatic send_bit(input logic lr, input logic b, input int half, input int act,
                          input bit push, input ev_t e);
    ev_t ev;
    i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_din = b;
    repeat (half) @(negedge clk);
    if (act == 1) begin
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      m_run = 0; m_lv = 0; m_out_l = '0; m_out_r = '0;
    end
    if (act == 2) begin
      reset = 1'b0; m_run = 0; m_lv = 0; m_out_l = '0; m_out_r = '0;
      @(negedge clk);
    end
    i2s_bclk = 1'b1;
    if (push) begin
      ev = e;
      ev.cyc = cyc + SS + 1;
      evq.push_back(ev);
    end
    if (act == 3) begin
      repeat (3) @(negedge clk);
      i2s_lrclk = ~lr; @(negedge clk); i2s_lrclk = lr;
      repeat (half - 4) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
  endtask

  // Sends one word; its LSB goes out with the next word's LRCLK (one-bit delay).
  task automatic send_word(input logic ch, input logic [31:0] data, input int n,
                           input int half, input int act_bit, input int act);
    ev_t         e;
    bit          push;
    logic [15:0] word;
    push = 0;
    e = '{l:16'h0, r:16'h0, stb:1'b0, err:1'b0, cyc:0};
    if (has_pend) begin
      if (ch != cur_ch && !reset) begin
        if (!m_run) m_run = 1;
        else begin
          word  = align(cur_data, cur_n);
          e.err = (cur_n < 16);
          if (cur_ch == I2S_LEFT) begin
            m_lhold = word; m_lv = 1;
          end else if (m_lv) begin
            e.stb = 1; m_out_l = m_lhold; m_out_r = word; m_lv = 0; n_stb_exp++;
          end
          e.l = m_out_l; e.r = m_out_r;
          push = e.stb || e.err;
        end
      end
      send_bit(ch, pend_bit, half, 0, push, e);
    end
    cur_ch = ch; cur_data = data; cur_n = n;
    for (int i = n - 1; i >= 1; i--)
      send_bit(ch, data[i], half, (n - 1 - i == act_bit) ? act : 0, 0, e);
    pend_bit = data[0];
    has_pend = 1;
  endtask

  always @(negedge clk) begin
    if (!reset && (sample_strobe || frame_err)) begin
      if (evq.size() == 0) begin
        chk("unexpected_event", {30'b0, sample_strobe, frame_err}, 32'h0);
      end else begin
        mon_e = evq.pop_front();
        chk("sample_strobe", 32'(sample_strobe), 32'(mon_e.stb));
        chk("frame_err", 32'(frame_err), 32'(mon_e.err));
        chk("audio_l", 32'(audio_l), 32'(mon_e.l));
        chk("audio_r", 32'(audio_r), 32'(mon_e.r));
        chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
      if (sample_strobe) n_stb_seen++;
    end
  end

  initial begin
    reset = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_din = 1'b0;
    m_run = 0; m_lv = 0; has_pend = 0; cur_ch = 1'b0; cur_n = 0; cur_data = '0;
    m_lhold = '0; m_out_l = '0; m_out_r = '0; pend_bit = 1'b0;
    repeat (3) @(negedge clk);

    // stream running while reset is held
    send_word(1'b0, 32'h1111, 16, 8, -1, 0);
    send_word(1'b1, 32'h2222, 16, 8, -1, 0);
    chk("rst_audio_l", 32'(audio_l), 32'h0);
    chk("rst_audio_r", 32'(audio_r), 32'h0);
    chk("rst_strobe", 32'(sample_strobe), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(WAIT_SYNC));

    // release mid left word, then 16-bit frames
    send_word(1'b0, 32'h1234, 16, 8, 5, 2);
    send_word(1'b1, 32'hABCD, 16, 8, -1, 0);
    for (int k = 0; k < 3; k++) begin
      send_word(1'b0, 32'h1234, 16, 8, -1, 0);
      send_word(1'b1, 32'hABCD, 16, 8, -1, 0);
    end

    // 24-bit data in 32-bit slots
    for (int k = 0; k < 2; k++) begin
      send_word(1'b0, 32'h12345600, 32, 8, -1, 0);
      send_word(1'b1, 32'hFEDCBA00, 32, 8, -1, 0);
    end

    // 8-bit short words
    for (int k = 0; k < 2; k++) begin
      send_word(1'b0, 32'hA5, 8, 8, -1, 0);
      send_word(1'b1, 32'h5A, 8, 8, -1, 0);
    end

    // reset pulse during bit 7 of a left word
    send_word(1'b0, 32'h1357, 16, 8, 7, 1);
    send_word(1'b1, 32'h2468, 16, 8, -1, 0);
    for (int k = 0; k < 2; k++) begin
      send_word(1'b0, 32'h1357, 16, 8, -1, 0);
      send_word(1'b1, 32'h2468, 16, 8, -1, 0);
    end

    // LRCLK glitch between BCLK rises must not create a boundary
    send_word(1'b0, 32'h0F0F, 16, 8, -1, 0);
    send_word(1'b1, 32'hF0F0, 16, 8, 4, 3);
    send_word(1'b0, 32'h8001, 16, 8, -1, 0);
    send_word(1'b1, 32'h7FFE, 16, 8, -1, 0);

    // BCLK at clk/4
    for (int k = 0; k < 2; k++) begin
      send_word(1'b0, 32'hC3A5, 16, 2, -1, 0);
      send_word(1'b1, 32'h5AC3, 16, 2, -1, 0);
    end
    send_word(1'b0, 32'h0000, 16, 2, -1, 0);
    repeat (20) @(negedge clk);

    chk("queue_drain", 32'(evq.size()), 32'h0);
    chk("strobe_count", 32'(n_stb_seen), 32'(n_stb_exp));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Deserialises a Philips-format I2S stream (BCLK, LRCLK, DATA) into parallel 16-bit left/right samples in the system clock domain. It is the receive-side counterpart of the `i2s_sound` transmitter. It lets an external codec, ADC or a loopback from our own transmitter feed audio samples into the core. All three I2S lines are treated as asynchronous inputs and oversampled by the system clock, so no BCLK-domain logic exists.

## Interface
Parameters:
- `WIDTH`, 16: output sample width in bits.
- `SYNC_STAGES`, 2: synchroniser depth for `i2s_bclk`, `i2s_lrclk` and `i2s_din`; minimum 2.

Ports:
- `clk`, in, 1: system clock (50 MHz in current boards). One clock. Reset is asynchronous and active-high.
- `reset`, in, 1: asynchronous, active-high reset.
- `i2s_bclk`, in, 1: bit clock, asynchronous to `clk`.
- `i2s_lrclk`, in, 1: word select; 0 = left, 1 = right. Asynchronous.
- `i2s_din`, in, 1: serial data, MSB first. Asynchronous.
- `audio_l`, out, WIDTH: last complete left sample.
- `audio_r`, out, WIDTH: last complete right sample.
- `sample_strobe`, out, 1: one-`clk` pulse; `audio_l` and `audio_r` were updated together this cycle.
- `frame_err`, out, 1: one-`clk` pulse; a completed word carried fewer than WIDTH bits.

## Operation
- **Synchronisation:** each input passes through SYNC_STAGES flops. A BCLK rise is detected when the synced BCLK is 1 and the registered previous value is 0. All sampling happens only on detected rises, and BCLK falls are ignored.
- **Sampling:** on each rise, sample synced `din` as `bit` and synced `lrclk` as `lr`. Keep `lr_prev` (previous sampled `lr`), `shreg[WIDTH-1:0]`, and `cnt` (saturates at WIDTH).
- **Bit placement:** on every rise in RUN, if `cnt` < WIDTH, write `bit` into `shreg[WIDTH-1-cnt]` and increment `cnt`. Bits beyond WIDTH are discarded, so longer words (24/32-bit) are truncated to their top WIDTH bits.
- **Word boundary:** a boundary is a rise where `lr` != `lr_prev`. The bit sampled at that rise still belongs to the old word (I2S one-bit delay), so it is placed first. The old word then completes:
  - Old channel left (`lr_prev`=0): store into `left_hold` and set `left_valid`.
  - Old channel right: if `left_valid`, load `audio_l` from `left_hold` and `audio_r` from the word, pulse `sample_strobe`, and clear `left_valid`. A right word completing without `left_valid` is dropped silently.
  - If the completed word had `cnt` < WIDTH, pulse `frame_err`. The short word is still delivered left-aligned, with unused LSBs zero.
  - Then clear `shreg` to 0 and `cnt` to 0.
- **States:**
  - WAIT_SYNC (entered at reset): track `lr_prev` only. The first boundary moves to RUN with `shreg` and `cnt` cleared, and the partial word is discarded without `frame_err`.
  - RUN: normal operation. There is no exit except reset.
- **Reset values:** `audio_l`=0, `audio_r`=0, `sample_strobe`=0, `frame_err`=0, `left_valid`=0, `shreg`=0, `cnt`=0, `lr_prev`=0, state WAIT_SYNC, all synchroniser flops 0. Reset mid-frame discards everything, and the block resyncs on the next boundary.

## Timing
- BCLK high and low phases must each be at least 2 `clk` periods; BCLK ≤ `clk`/4. 3.072 MHz (48 kHz × 64) at 50 MHz is well inside this.
- LRCLK and DIN must be stable for at least 1 `clk` around the BCLK rise. Transmitters change them on the BCLK fall, which satisfies this.
- Latency: `sample_strobe`, `audio_l` and `audio_r` update on the `clk` edge SYNC_STAGES+1 cycles after the pin-level BCLK rise that sampled the right word's LSB (the LR 1→0 boundary). `frame_err` has the same latency.
- `audio_l` and `audio_r` hold their values between strobes. Both outputs change only in the cycle of `sample_strobe`.
- `sample_strobe` and `frame_err` can coincide.

## Structure
- Package `i2s_pkg`:
  - `I2S_LEFT` = 1'b0 and `I2S_RIGHT` = 1'b1 constants, shared with `i2s_sound`.
  - State enum `{WAIT_SYNC, RUN}`.
  - Default width constant 16.
- Sub-module `i2s_sync`: a parameterised SYNC_STAGES-deep synchroniser. It is instantiated three times (BCLK, LRCLK, DIN), with a rise-detect output on the BCLK instance.
- The main module holds the FSM, shift register, counter, holding register and output registers.

## Test plan
- **Reset:** assert `reset` with the BCLK/LRCLK stream running → all outputs are 0, no strobe, state WAIT_SYNC. Deassert: the first partial word is discarded, and the first strobe follows the first complete L+R pair.
- **16-bit frames:** 32-BCLK frames with L=0x1234, R=0xABCD at 3.072 MHz → one strobe per frame, `audio_l`=0x1234, `audio_r`=0xABCD, `frame_err` never pulses. Check strobe timing against SYNC_STAGES+1.
- **24-bit frames:** 64-BCLK frames with L=0x123456, R=0xFEDCBA → `audio_l`=0x1234, `audio_r`=0xFEDC, no `frame_err`.
- **Short words:** 8-bit words L=0xA5, R=0x5A → `audio_l`=0xA500, `audio_r`=0x5A00, and two `frame_err` pulses per frame.
- **Reset mid-frame:** pulse `reset` for 1 cycle during bit 7 of a left word → no strobe for that frame. The next full frame delivers correct values.
- **Boundary and speed stress:**
  - Glitch LRCLK so a right word follows a right word without a left → no strobe until a new L+R pair arrives.
  - Run BCLK at exactly `clk`/4 → values remain correct.
